// File: rtl/led_breathe_pwm.sv
// Breathing LED stage: a brightness FSM ramps a level up/hold/down/hold and per-LED PWM
// comparators turn it into duty cycles. Define LED_GAMMA_EN for square-law gamma on duties.
module led_breathe_pwm #(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned STEP_PERIODS = 4,
    parameter int unsigned HOLD_PERIODS = 32
) (
    input  logic                CLK_IN,
    input  logic                RST_IN,
    input  logic                EN_IN,
    output logic                GLED5,
    output logic                RLED1,
    output logic                RLED2,
    output logic                RLED3,
    output logic                RLED4,
    output logic [PWM_BITS-1:0] LEVEL_OUT
);

    localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned StepW  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int unsigned HoldW  = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [PrescW-1:0]   PrescLast = PrescW'(PRESCALE - 1);
    localparam logic [StepW-1:0]    StepLast  = StepW'(STEP_PERIODS - 1);
    localparam logic [HoldW-1:0]    HoldLast  = HoldW'(HOLD_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] Max       = '1;

    typedef enum logic [1:0] {StRise, StHoldHi, StFall, StHoldLo} state_e;

    state_e              state_q, state_d;
    logic [PrescW-1:0]   presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [StepW-1:0]    step_cnt_q, step_cnt_d;
    logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] duty_g_q, duty_g_d;
    logic [PWM_BITS-1:0] duty_r13_q, duty_r13_d;
    logic [PWM_BITS-1:0] duty_r24_q, duty_r24_d;
    logic                gled_q, gled_d;
    logic                rled13_q, rled13_d;
    logic                rled24_q, rled24_d;

    logic tick;
    logic period_end;

    assign tick       = EN_IN && (presc_q == PrescLast);
    assign period_end = tick && (pwm_cnt_q == Max);

`ifdef LED_GAMMA_EN
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] x);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, x} * {{PWM_BITS{1'b0}}, x};
        return sq[2*PWM_BITS-1 -: PWM_BITS];
    endfunction

    logic [PWM_BITS-1:0] gamma_lvl;
    logic [PWM_BITS-1:0] gamma_inv;
    assign gamma_lvl = gamma(level_q);
    assign gamma_inv = gamma(Max - level_q);
`endif

    always_comb begin
        presc_d   = presc_q;
        pwm_cnt_d = pwm_cnt_q;
        if (EN_IN) begin
            presc_d = (presc_q == PrescLast) ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end
    end

    // Duties sample the pre-update level, so a level change lands one period later.
    always_comb begin
        duty_g_d   = duty_g_q;
        duty_r13_d = duty_r13_q;
        duty_r24_d = duty_r24_q;
        if (period_end) begin
`ifdef LED_GAMMA_EN
            duty_g_d   = gamma_lvl;
            duty_r13_d = gamma_inv;
            duty_r24_d = gamma_lvl >> 1;
`else
            duty_g_d   = level_q;
            duty_r13_d = Max - level_q;
            duty_r24_d = level_q >> 1;
`endif
        end
    end

    always_comb begin
        gled_d   = EN_IN && (pwm_cnt_q < duty_g_q);
        rled13_d = EN_IN && (pwm_cnt_q < duty_r13_q);
        rled24_d = EN_IN && (pwm_cnt_q < duty_r24_q);
    end

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        step_cnt_d = step_cnt_q;
        hold_cnt_d = hold_cnt_q;
        if (period_end) begin
            unique case (state_q)
                StRise: begin
                    if (step_cnt_q == StepLast) begin
                        step_cnt_d = '0;
                        level_d    = (level_q == Max) ? Max : level_q + 1'b1;
                        if (level_d == Max) begin
                            state_d    = StHoldHi;
                            hold_cnt_d = '0;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                StHoldHi: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d    = StFall;
                        step_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                StFall: begin
                    if (step_cnt_q == StepLast) begin
                        step_cnt_d = '0;
                        level_d    = (level_q == '0) ? '0 : level_q - 1'b1;
                        if (level_d == '0) begin
                            state_d    = StHoldLo;
                            hold_cnt_d = '0;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                StHoldLo: begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d    = StRise;
                        step_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: state_d = StRise;
            endcase
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q    <= StRise;
            presc_q    <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            hold_cnt_q <= '0;
            level_q    <= '0;
            duty_g_q   <= '0;
            duty_r13_q <= '0;
            duty_r24_q <= '0;
            gled_q     <= 1'b0;
            rled13_q   <= 1'b0;
            rled24_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            duty_g_q   <= duty_g_d;
            duty_r13_q <= duty_r13_d;
            duty_r24_q <= duty_r24_d;
            gled_q     <= gled_d;
            rled13_q   <= rled13_d;
            rled24_q   <= rled24_d;
        end
    end

    assign GLED5     = gled_q;
    assign RLED1     = rled13_q;
    assign RLED3     = rled13_q;
    assign RLED2     = rled24_q;
    assign RLED4     = rled24_q;
    assign LEVEL_OUT = level_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Directed bench for led_breathe_pwm with PWM_BITS=4, PRESCALE=2, STEP_PERIODS=1,
// HOLD_PERIODS=2 (32 clk per PWM period). Honours LED_GAMMA_EN for the duty checks.
module tb_led_breathe_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       gled5, rled1, rled2, rled3, rled4;
    logic [3:0] level;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    led_breathe_pwm #(
        .PWM_BITS    (4),
        .PRESCALE    (2),
        .STEP_PERIODS(1),
        .HOLD_PERIODS(2)
    ) dut (
        .CLK_IN   (clk),
        .RST_IN   (rst),
        .EN_IN    (en),
        .GLED5    (gled5),
        .RLED1    (rled1),
        .RLED2    (rled2),
        .RLED3    (rled3),
        .RLED4    (rled4),
        .LEVEL_OUT(level)
    );

    always #5 clk = ~clk;

    // Advance to just after rising edge number 'target' (sampled on the falling edge).
    task automatic adv_to(input int target);
        while (edge_n < target) begin
            @(negedge clk);
            edge_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL reset_level: got %0d, expected 0", level);
        end
        checks++;
        if ({gled5, rled1, rled2, rled3, rled4} !== 5'b0) begin
            errors++;
            $display("FAIL reset_leds: got %b, expected 00000",
                     {gled5, rled1, rled2, rled3, rled4});
        end
        rst    = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_ramp_start(input string tag);
        int any_hi;
        int g_hi;
        int r1_hi;
        any_hi = 0;
        while (edge_n < 31) begin
            adv_to(edge_n + 1);
            if ({gled5, rled1, rled2, rled3, rled4} != 5'b0) any_hi++;
        end
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL %s_level_at31: got %0d, expected 0", tag, level);
        end
        adv_to(32);
        if ({gled5, rled1, rled2, rled3, rled4} != 5'b0) any_hi++;
        checks++;
        if (any_hi !== 0) begin
            errors++;
            $display("FAIL %s_period1_dark: got %0d lit samples, expected 0", tag, any_hi);
        end
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL %s_level_at32: got %0d, expected 1", tag, level);
        end
        g_hi  = 0;
        r1_hi = 0;
        while (edge_n < 64) begin
            adv_to(edge_n + 1);
            if (gled5) g_hi++;
            if (rled1) r1_hi++;
        end
        checks++;
        if (g_hi !== 0) begin
            errors++;
            $display("FAIL %s_gled_period2: got %0d high clk, expected 0", tag, g_hi);
        end
        checks++;
        if (r1_hi !== 30) begin
            errors++;
            $display("FAIL %s_rled1_period2: got %0d high clk, expected 30", tag, r1_hi);
        end
        adv_to(65);
        checks++;
        if (gled5 !== 1'b1) begin
            errors++;
            $display("FAIL %s_gled_p3_c1: got %b, expected 1", tag, gled5);
        end
        adv_to(66);
        checks++;
        if (gled5 !== 1'b1) begin
            errors++;
            $display("FAIL %s_gled_p3_c2: got %b, expected 1", tag, gled5);
        end
        adv_to(67);
        checks++;
        if (gled5 !== 1'b0) begin
            errors++;
            $display("FAIL %s_gled_p3_c3: got %b, expected 0", tag, gled5);
        end
    endtask

    task automatic test_hold_hi();
        int g_hi;
        int r1_hi;
        adv_to(479);
        checks++;
        if (level !== 4'd14) begin
            errors++;
            $display("FAIL hold_level_at479: got %0d, expected 14", level);
        end
        adv_to(480);
        checks++;
        if (level !== 4'd15) begin
            errors++;
            $display("FAIL hold_level_at480: got %0d, expected 15", level);
        end
        adv_to(512);
        g_hi  = 0;
        r1_hi = 0;
        while (edge_n < 544) begin
            adv_to(edge_n + 1);
            if (gled5) g_hi++;
            if (rled1) r1_hi++;
        end
        checks++;
        if (g_hi !== 30) begin
            errors++;
            $display("FAIL hold_gled_duty: got %0d high clk, expected 30", g_hi);
        end
        checks++;
        if (r1_hi !== 0) begin
            errors++;
            $display("FAIL hold_rled1_duty: got %0d high clk, expected 0", r1_hi);
        end
        checks++;
        if (level !== 4'd15) begin
            errors++;
            $display("FAIL hold_level_at544: got %0d, expected 15", level);
        end
        adv_to(575);
        checks++;
        if (level !== 4'd15) begin
            errors++;
            $display("FAIL hold_level_at575: got %0d, expected 15", level);
        end
        adv_to(576);
        checks++;
        if (level !== 4'd14) begin
            errors++;
            $display("FAIL hold_level_at576: got %0d, expected 14", level);
        end
    endtask

    task automatic test_full_cycle();
        int prev;
        int cur;
        int jumps;
        int downs;
        int ups;
        prev  = 14;
        jumps = 0;
        downs = 0;
        ups   = 0;
        while (edge_n < 1120) begin
            adv_to(edge_n + 1);
            cur = int'(level);
            if (cur == prev - 1) downs++;
            else if (cur == prev + 1) ups++;
            else if (cur != prev) jumps++;
            prev = cur;
            if (edge_n == 1023) begin
                checks++;
                if (level !== 4'd1) begin
                    errors++;
                    $display("FAIL cycle_level_at1023: got %0d, expected 1", level);
                end
            end
            if (edge_n == 1024) begin
                checks++;
                if (level !== 4'd0) begin
                    errors++;
                    $display("FAIL cycle_level_at1024: got %0d, expected 0", level);
                end
            end
            if (edge_n == 1119) begin
                checks++;
                if (level !== 4'd0) begin
                    errors++;
                    $display("FAIL cycle_level_at1119: got %0d, expected 0", level);
                end
            end
        end
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL cycle_level_at1120: got %0d, expected 1", level);
        end
        checks++;
        if (jumps !== 0) begin
            errors++;
            $display("FAIL cycle_no_wrap: got %0d jumps, expected 0", jumps);
        end
        checks++;
        if (downs !== 14 || ups !== 1) begin
            errors++;
            $display("FAIL cycle_steps: got %0d down/%0d up, expected 14/1", downs, ups);
        end
    endtask

    task automatic test_freeze();
        int lit;
        int moved;
        adv_to(1312);
        checks++;
        if (level !== 4'd7) begin
            errors++;
            $display("FAIL freeze_level_at1312: got %0d, expected 7", level);
        end
        adv_to(1320);
        en    = 1'b0;
        lit   = 0;
        moved = 0;
        repeat (100) begin
            adv_to(edge_n + 1);
            if ({gled5, rled1, rled2, rled3, rled4} != 5'b0) lit++;
            if (level != 4'd7) moved++;
        end
        checks++;
        if (lit !== 0) begin
            errors++;
            $display("FAIL freeze_leds_dark: got %0d lit samples, expected 0", lit);
        end
        checks++;
        if (moved !== 0) begin
            errors++;
            $display("FAIL freeze_level_held: got %0d changed samples, expected 0", moved);
        end
        en = 1'b1;
        adv_to(1443);
        checks++;
        if (level !== 4'd7) begin
            errors++;
            $display("FAIL freeze_level_at1443: got %0d, expected 7", level);
        end
        adv_to(1444);
        checks++;
        if (level !== 4'd8) begin
            errors++;
            $display("FAIL freeze_level_at1444: got %0d, expected 8", level);
        end
    endtask

    task automatic test_async_reset();
        adv_to(1892);
        checks++;
        if (level !== 4'd10) begin
            errors++;
            $display("FAIL areset_level_at1892: got %0d, expected 10", level);
        end
        adv_to(1900);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL areset_level_now: got %0d, expected 0", level);
        end
        checks++;
        if ({gled5, rled1, rled2, rled3, rled4} !== 5'b0) begin
            errors++;
            $display("FAIL areset_leds_now: got %b, expected 00000",
                     {gled5, rled1, rled2, rled3, rled4});
        end
        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;
        test_ramp_start("after_reset");
    endtask

    task automatic test_duty();
        int n_g;
        int n_r1;
        int n_r2;
        int n_r3;
        int n_r4;
        int e_g;
        int e_r13;
        int e_r24;
`ifdef LED_GAMMA_EN
        e_g   = 8;
        e_r13 = 6;
        e_r24 = 4;
`else
        e_g   = 16;
        e_r13 = 14;
        e_r24 = 8;
`endif
        adv_to(256);
        checks++;
        if (level !== 4'd8) begin
            errors++;
            $display("FAIL duty_level_at256: got %0d, expected 8", level);
        end
        adv_to(288);
        n_g  = 0;
        n_r1 = 0;
        n_r2 = 0;
        n_r3 = 0;
        n_r4 = 0;
        while (edge_n < 320) begin
            adv_to(edge_n + 1);
            if (gled5) n_g++;
            if (rled1) n_r1++;
            if (rled2) n_r2++;
            if (rled3) n_r3++;
            if (rled4) n_r4++;
        end
        checks++;
        if (n_g !== e_g) begin
            errors++;
            $display("FAIL duty_gled5: got %0d high clk, expected %0d", n_g, e_g);
        end
        checks++;
        if (n_r1 !== e_r13) begin
            errors++;
            $display("FAIL duty_rled1: got %0d high clk, expected %0d", n_r1, e_r13);
        end
        checks++;
        if (n_r3 !== e_r13) begin
            errors++;
            $display("FAIL duty_rled3: got %0d high clk, expected %0d", n_r3, e_r13);
        end
        checks++;
        if (n_r2 !== e_r24) begin
            errors++;
            $display("FAIL duty_rled2: got %0d high clk, expected %0d", n_r2, e_r24);
        end
        checks++;
        if (n_r4 !== e_r24) begin
            errors++;
            $display("FAIL duty_rled4: got %0d high clk, expected %0d", n_r4, e_r24);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_start("start");
        test_hold_hi();
        test_full_cycle();
        test_freeze();
        test_async_reset();
        test_duty();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
